ip_hdr_tx_ctrl: RTL and testbench

Sequencer for IPv4 header generation on the 1000M Ethernet transmit path. It accepts one packet request at a time and latches the header fields. It then computes the header checksum serially, one 16-bit word per cycle. Finally it streams the 20-byte header, MSB first, to the MAC framer over a valid/ready byte interface. It sits between the UDP/packet scheduler (upstream) and the Ethernet frame assembler (downstream).

---
 rtl/ip_tx_pkg.sv | 23 ++
 rtl/ip_csum_acc.sv | 47 ++++
 rtl/ip_hdr_tx_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_ip_hdr_tx_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ip_tx_pkg.sv
// rtl/ip_tx_pkg.sv - shared types and constants for the IPv4 header transmit controller
package ip_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SUM   = 3'd1,
        ST_FOLD1 = 3'd2,
        ST_FOLD2 = 3'd3,
        ST_SEND  = 3'd4
    } state_e;

    localparam logic [15:0] IP_VER_IHL_TOS = 16'h4500;
    localparam logic [15:0] IP_FLAGS_OFF   = 16'h4000;
    localparam int          IP_HDR_BYTES   = 20;
    localparam int          IP_HDR_WORDS   = 10;
    localparam logic [15:0] IP_MAX_PAYLOAD = 16'hFFEB;

    // Big-endian byte pick from a header word.
    function automatic logic [7:0] word_byte(input logic [15:0] w, input logic lo);
        return lo ? w[7:0] : w[15:8];
    endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// rtl/ip_csum_acc.sv - serial one's-complement accumulator for the IPv4 header checksum
module ip_csum_acc (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        add_en_i,
    input  logic [15:0] word_i,
    input  logic        fold1_i,
    input  logic        fold2_i,
    output logic [15:0] csum_o
);

    logic [19:0] acc_q, acc_d;
    logic [15:0] csum_q, csum_d;
    logic [16:0] fold1_sum;

    // Ten 16-bit words fit in 20 bits, so the first fold needs only the top nibble.
    assign fold1_sum = {1'b0, acc_q[15:0]} + {13'b0, acc_q[19:16]};

    always_comb begin
        acc_d  = acc_q;
        csum_d = csum_q;
        if (clr_i) begin
            acc_d = 20'h0;
        end else if (add_en_i) begin
            acc_d = acc_q + {4'h0, word_i};
        end else if (fold1_i) begin
            acc_d = {3'b0, fold1_sum};
        end
        if (fold2_i) begin
            csum_d = ~(acc_q[15:0] + {15'h0, acc_q[16]});
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q  <= 20'h0;
            csum_q <= 16'h0;
        end else begin
            acc_q  <= acc_d;
            csum_q <= csum_d;
        end
    end

    assign csum_o = csum_q;

endmodule

// File: rtl/ip_hdr_tx_ctrl.sv
// rtl/ip_hdr_tx_ctrl.sv - IPv4 header sequencer: latch request, serial checksum, stream 20 bytes
module ip_hdr_tx_ctrl
    import ip_tx_pkg::*;
#(
    parameter logic [31:0] SRC_IP   = 32'hC0A8_0102,
    parameter logic [7:0]  TTL      = 8'd64,
    parameter logic [7:0]  PROTOCOL = 8'd17
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] dst_ip_i,
    input  logic [15:0] payload_len_i,
    output logic        busy_o,
    output logic        err_len_o,
    output logic [7:0]  hdr_data_o,
    output logic        hdr_valid_o,
    input  logic        hdr_ready_i,
    output logic        hdr_last_o,
    output logic [15:0] hdr_checksum_o
);

    state_e      state_q, state_d;
    logic [31:0] dst_q, dst_d;
    logic [15:0] tot_len_q, tot_len_d;
    logic [15:0] id_q, id_d;
    logic [3:0]  idx_q, idx_d;
    logic [4:0]  bidx_q, bidx_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;

    logic        acc_clr, acc_add, acc_fold1, acc_fold2;
    logic [15:0] csum;
    logic        req, len_ok, accept, reject, xfer;
    logic [4:0]  nxt_bidx;
    logic [15:0] sum_word, nxt_word, first_word;

    // Word 5 is the checksum slot: zero while summing, the result while sending.
    function automatic logic [15:0] hdr_word(input logic [3:0] i, input logic [15:0] ck);
        case (i)
            4'd0:    return IP_VER_IHL_TOS;
            4'd1:    return tot_len_q;
            4'd2:    return id_q;
            4'd3:    return IP_FLAGS_OFF;
            4'd4:    return {TTL, PROTOCOL};
            4'd5:    return ck;
            4'd6:    return SRC_IP[31:16];
            4'd7:    return SRC_IP[15:0];
            4'd8:    return dst_q[31:16];
            4'd9:    return dst_q[15:0];
            default: return 16'h0;
        endcase
    endfunction

    assign req        = (state_q == ST_IDLE) && start_i;
    assign len_ok     = (payload_len_i <= IP_MAX_PAYLOAD);
    assign accept     = req && len_ok;
    assign reject     = req && !len_ok;
    assign xfer       = valid_q && hdr_ready_i;
    assign nxt_bidx   = bidx_q + 5'd1;
    assign sum_word   = hdr_word(idx_q, 16'h0);
    assign nxt_word   = hdr_word(nxt_bidx[4:1], csum);
    assign first_word = hdr_word(4'd0, csum);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SUM;
            ST_SUM:   if (idx_q == 4'(IP_HDR_WORDS - 1)) state_d = ST_FOLD1;
            ST_FOLD1: state_d = ST_FOLD2;
            ST_FOLD2: state_d = ST_SEND;
            ST_SEND:  if (xfer && last_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dst_d     = dst_q;
        tot_len_d = tot_len_q;
        id_d      = id_q;
        idx_d     = idx_q;
        bidx_d    = bidx_q;
        busy_d    = busy_q;
        err_d     = reject;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        acc_clr   = 1'b0;
        acc_add   = 1'b0;
        acc_fold1 = 1'b0;
        acc_fold2 = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    busy_d    = 1'b1;
                    dst_d     = dst_ip_i;
                    tot_len_d = payload_len_i + 16'(IP_HDR_BYTES);
                    idx_d     = 4'd0;
                    acc_clr   = 1'b1;
                end
            end
            ST_SUM: begin
                acc_add = 1'b1;
                idx_d   = idx_q + 4'd1;
            end
            ST_FOLD1: acc_fold1 = 1'b1;
            ST_FOLD2: begin
                acc_fold2 = 1'b1;
                bidx_d    = 5'd0;
                valid_d   = 1'b1;
                last_d    = 1'b0;
                data_d    = word_byte(first_word, 1'b0);
            end
            ST_SEND: begin
                if (xfer) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        id_d    = id_q + 16'd1;
                    end else begin
                        bidx_d = nxt_bidx;
                        data_d = word_byte(nxt_word, nxt_bidx[0]);
                        last_d = (nxt_bidx == 5'(IP_HDR_BYTES - 1));
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dst_q     <= 32'h0;
            tot_len_q <= 16'h0;
            id_q      <= 16'h0;
            idx_q     <= 4'h0;
            bidx_q    <= 5'h0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            data_q    <= 8'h0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            dst_q     <= dst_d;
            tot_len_q <= tot_len_d;
            id_q      <= id_d;
            idx_q     <= idx_d;
            bidx_q    <= bidx_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
        end
    end

    ip_csum_acc u_csum (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (acc_clr),
        .add_en_i (acc_add),
        .word_i   (sum_word),
        .fold1_i  (acc_fold1),
        .fold2_i  (acc_fold2),
        .csum_o   (csum)
    );

    assign busy_o         = busy_q;
    assign err_len_o      = err_q;
    assign hdr_data_o     = data_q;
    assign hdr_valid_o    = valid_q;
    assign hdr_last_o     = last_q;
    assign hdr_checksum_o = csum;

endmodule

// File: tb/tb_ip_hdr_tx_ctrl.sv
// tb/tb_ip_hdr_tx_ctrl.sv - scoreboard bench for ip_hdr_tx_ctrl
module tb_ip_hdr_tx_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dst_ip = 32'h0;
    logic [15:0] payload_len = 16'h0;
    logic        busy, err_len, hdr_valid, hdr_last;
    logic [7:0]  hdr_data;
    logic        hdr_ready = 1'b1;
    logic [15:0] hdr_checksum;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [15:0] exp_id = 16'h0;
    logic [7:0]  exp_q[$];
    int acc_cyc, prev_acc_cyc;

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ip_hdr_tx_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .dst_ip_i       (dst_ip),
        .payload_len_i  (payload_len),
        .busy_o         (busy),
        .err_len_o      (err_len),
        .hdr_data_o     (hdr_data),
        .hdr_valid_o    (hdr_valid),
        .hdr_ready_i    (hdr_ready),
        .hdr_last_o     (hdr_last),
        .hdr_checksum_o (hdr_checksum)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_csum(input logic [31:0] d, input logic [15:0] len,
                                               input logic [15:0] id);
        logic [31:0] s;
        s = 32'h4500 + 32'(len + 16'd20) + 32'(id) + 32'h4000 + 32'h4011
          + 32'hC0A8 + 32'h0102 + 32'(d[31:16]) + 32'(d[15:0]);
        while (s[31:16] != 16'h0) s = 32'(s[15:0]) + 32'(s[31:16]);
        return ~s[15:0];
    endfunction

    task automatic push_hdr(input logic [31:0] d, input logic [15:0] len, input logic [15:0] id);
        logic [15:0] w[10];
        w[0] = 16'h4500; w[1] = len + 16'd20; w[2] = id; w[3] = 16'h4000;
        w[4] = 16'h4011; w[5] = model_csum(d, len, id);
        w[6] = 16'hC0A8; w[7] = 16'h0102; w[8] = d[31:16]; w[9] = d[15:0];
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(w[i][15:8]);
            exp_q.push_back(w[i][7:0]);
        end
    endtask

    // Issue one request and consume its header, optionally stalling, re-pulsing start or resetting.
    task automatic run_pkt(input logic [31:0] d, input logic [15:0] len, input int stall_at,
                           input int stall_len, input int start_at, input int rst_at);
        int lat, xfer, cycles, stalled;
        logic pulsed, have_hold;
        logic [7:0] held, e;
        @(negedge clk);
        start = 1'b1; dst_ip = d; payload_len = len; hdr_ready = 1'b1;
        @(posedge clk);
        prev_acc_cyc = acc_cyc;
        #1;
        acc_cyc = cyc;
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        push_hdr(d, len, exp_id);
        lat = 0;
        while (!hdr_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("first_byte_latency", lat, 12);
        xfer = 0; cycles = 0; stalled = 0; pulsed = 1'b0; have_hold = 1'b0; held = 8'h0;
        while (xfer < 20 && cycles < 80) begin
            @(negedge clk);
            hdr_ready = !(xfer == stall_at && stalled < stall_len);
            if (!hdr_ready) stalled++;
            start = (xfer == start_at) && !pulsed;
            if (start) pulsed = 1'b1;
            if (xfer == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_valid", 32'(hdr_valid), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_data_last", {hdr_data, 7'h0, hdr_last}, 32'h0);
                chk("rst_checksum", 32'(hdr_checksum), 32'h0);
                exp_q.delete();
                exp_id = 16'h0;
                @(negedge clk);
                rst = 1'b0; hdr_ready = 1'b1; start = 1'b0;
                return;
            end
            #1;
            chk("valid_in_send", 32'(hdr_valid), 32'd1);
            if (have_hold) chk("hold_stable", 32'(hdr_data), 32'(held));
            if (hdr_valid && hdr_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("byte%0d", xfer), 32'(hdr_data), 32'(e));
                    chk($sformatf("last%0d", xfer), 32'(hdr_last), 32'(exp_q.size() == 0));
                end
                xfer++;
                have_hold = 1'b0;
            end else begin
                held = hdr_data;
                have_hold = 1'b1;
            end
            cycles++;
        end
        chk("xfer_cycles", cycles, 20 + stall_len);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_fall", 32'(busy), 32'd0);
        chk("valid_fall", 32'(hdr_valid), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("checksum_reg", 32'(hdr_checksum), 32'(model_csum(d, len, exp_id)));
        exp_id = exp_id + 16'd1;
    endtask

    task automatic idle_watch(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (hdr_valid || busy) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        acc_cyc = 0; prev_acc_cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {busy, err_len, hdr_valid, hdr_last, hdr_data}, 32'h0);
        chk("reset_checksum", 32'(hdr_checksum), 32'h0);
        @(negedge clk); rst = 1'b0;

        run_pkt(32'hC0A8_0103, 16'h0010, -1, 0, -1, -1);
        chk("single_checksum", 32'(hdr_checksum), 32'hB773);

        run_pkt(32'hC0A8_0103, 16'h0010, -1, 0, -1, -1);
        chk("b2b_checksum", 32'(hdr_checksum), 32'hB772);
        chk("b2b_spacing", acc_cyc - prev_acc_cyc, 33);

        run_pkt(32'h0A00_0001, 16'h05C8, 5, 3, -1, -1);

        run_pkt(32'hAC10_FFFE, 16'h0000, -1, 0, 3, -1);
        idle_watch("start_during_busy_ignored", 20);

        run_pkt(32'hFFFF_FFFF, 16'hFFEB, -1, 0, -1, -1);

        @(negedge clk); start = 1'b1; payload_len = 16'hFFEC;
        @(posedge clk); #1;
        chk("err_len_pulse", {err_len, busy}, 32'h2);
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        chk("err_len_one_cycle", 32'(err_len), 32'd0);
        idle_watch("reject_no_output", 15);

        run_pkt(32'hC0A8_0103, 16'h0010, -1, 0, -1, 8);
        run_pkt(32'hC0A8_0103, 16'h0010, -1, 0, -1, -1);
        chk("post_reset_checksum", 32'(hdr_checksum), 32'hB773);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
